// File: rtl/entrada_pkg.sv
// Shared types and the BCD code validity rule for the Bulls and Cows input path.
// The game core reuses code_valid() for its own guess checking.
package entrada_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } btn_state_t;

    localparam int N_DIGITS = 4;

    // A code is usable only if every digit is decimal and no digit repeats.
    function automatic logic code_valid(input logic [15:0] code);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (code[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end
            for (int j = i + 1; j < N_DIGITS; j++) begin
                if (code[4*i +: 4] == code[4*j +: 4]) begin
                    ok = 1'b0;
                end
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/sincronizador.sv
// Multi-flop synchronizer chain for asynchronous board inputs.
// Each bit is synchronized independently; callers must not rely on cross-bit coherence.
module sincronizador #(
    parameter int DATA_W      = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] async_i,
    output logic [DATA_W-1:0] sync_o
);

    logic [DATA_W-1:0] stage_q [SYNC_STAGES];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= async_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign sync_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/entrada_cond.sv
// Input conditioner: synchronizes switches and enter button, debounces the button,
// and turns each debounced press into a single accept or reject strobe.
module entrada_cond
    import entrada_pkg::*;
#(
    parameter  int DEBOUNCE_CYCLES = 1_000_000,
    parameter  int SYNC_STAGES     = 2,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] code_raw,
    input  logic        enter_raw,
    output logic [15:0] code_q,
    output logic        accept_pulse,
    output logic        reject_pulse,
    output logic        btn_held
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic        btn_s;
    logic [15:0] code_s;

    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_evt;
    logic             valid;
    logic [15:0]      code_d;
    logic             accept_d, reject_d;

    sincronizador #(.DATA_W(1), .SYNC_STAGES(SYNC_STAGES)) u_sync_btn (
        .clock  (clock),
        .reset  (reset),
        .async_i(enter_raw),
        .sync_o (btn_s)
    );

    sincronizador #(.DATA_W(16), .SYNC_STAGES(SYNC_STAGES)) u_sync_code (
        .clock  (clock),
        .reset  (reset),
        .async_i(code_raw),
        .sync_o (code_s)
    );

    // The edge that would bring the counter to CNT_MAX is the one that commits the
    // level change, so a clean edge is reported SYNC_STAGES+DEBOUNCE_CYCLES cycles later.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_evt = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_MAX - CNT_ONE) begin
                    state_d   = HELD;
                    cnt_d     = '0;
                    press_evt = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_MAX - CNT_ONE) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign valid    = code_valid(code_s);
    assign accept_d = press_evt & valid;
    assign reject_d = press_evt & ~valid;
    assign code_d   = accept_d ? code_s : code_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            code_q       <= 16'h0000;
            accept_pulse <= 1'b0;
            reject_pulse <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            code_q       <= code_d;
            accept_pulse <= accept_d;
            reject_pulse <= reject_d;
        end
    end

    // The debounced level stays high until a release has been confirmed.
    assign btn_held = (state_q == HELD) || (state_q == RELEASE_WAIT);

endmodule

// File: tb/tb_entrada_cond.sv
// Randomized and directed bench for entrada_cond against a run-length reference model.
module tb_entrada_cond;

    localparam int D = 8;
    localparam int S = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enter_raw = 1'b0;
    logic [15:0] code_raw = 16'h0000;
    logic [15:0] code_q;
    logic        accept_pulse;
    logic        reject_pulse;
    logic        btn_held;

    entrada_cond #(.DEBOUNCE_CYCLES(D), .SYNC_STAGES(S)) dut (
        .clock       (clock),
        .reset       (reset),
        .code_raw    (code_raw),
        .enter_raw   (enter_raw),
        .code_q      (code_q),
        .accept_pulse(accept_pulse),
        .reject_pulse(reject_pulse),
        .btn_held    (btn_held)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;
    int n_acc  = 0;
    int n_rej  = 0;
    bit chk_en = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    endtask

    // Reference: a level change is accepted after D consecutive synchronized samples
    // that differ from the current debounced level.
    function automatic bit ref_valid(input logic [15:0] c);
        bit [9:0] seen;
        int       d;
        seen = '0;
        for (int i = 0; i < 4; i++) begin
            d = int'(c[i*4 +: 4]);
            if (d > 9) return 1'b0;
            if (seen[d]) return 1'b0;
            seen[d] = 1'b1;
        end
        return 1'b1;
    endfunction

    bit          mb [S];
    logic [15:0] mc [S];
    int          run  = 0;
    bit          lvl  = 1'b0;
    bit          macc = 1'b0;
    bit          mrej = 1'b0;
    logic [15:0] mcode = 16'h0000;

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < S; i++) begin
                mb[i] = 1'b0;
                mc[i] = 16'h0000;
            end
            run = 0; lvl = 1'b0; macc = 1'b0; mrej = 1'b0; mcode = 16'h0000;
        end else begin
            macc = 1'b0;
            mrej = 1'b0;
            if (mb[S-1] != lvl) begin
                run++;
                if (run == D) begin
                    run = 0;
                    lvl = mb[S-1];
                    if (lvl) begin
                        if (ref_valid(mc[S-1])) begin
                            macc  = 1'b1;
                            mcode = mc[S-1];
                        end else begin
                            mrej = 1'b1;
                        end
                    end
                end
            end else begin
                run = 0;
            end
            for (int i = S - 1; i > 0; i--) begin
                mb[i] = mb[i-1];
                mc[i] = mc[i-1];
            end
            mb[0] = enter_raw;
            mc[0] = code_raw;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check_eq("accept", accept_pulse, macc);
            check_eq("reject", reject_pulse, mrej);
            check_eq("code_q", code_q, mcode);
            check_eq("btn_held", btn_held, lvl);
            check_eq("exclusive", accept_pulse & reject_pulse, 0);
        end
        if (accept_pulse === 1'b1) n_acc++;
        if (reject_pulse === 1'b1) n_rej++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_pulse(input string tag, input int want);
        int lat;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (accept_pulse === 1'b1 || reject_pulse === 1'b1) begin
                lat = i;
                break;
            end
        end
        check_eq(tag, lat, want);
    endtask

    task automatic release_btn();
        enter_raw = 1'b0;
        cyc(D + S + 4);
    endtask

    function automatic logic [15:0] rand_code();
        int digs [10];
        int j, t;
        logic [15:0] c;
        if ($urandom_range(0, 1) == 0) return 16'($urandom);
        for (int i = 0; i < 10; i++) digs[i] = i;
        for (int i = 9; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            t = digs[i]; digs[i] = digs[j]; digs[j] = t;
        end
        c[15:12] = 4'(digs[0]);
        c[11:8]  = 4'(digs[1]);
        c[7:4]   = 4'(digs[2]);
        c[3:0]   = 4'(digs[3]);
        return c;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, r0;
        cyc(3);
        chk_en = 1'b1;
        check_eq("rst_code", code_q, 16'h0000);
        check_eq("rst_acc", accept_pulse, 0);
        check_eq("rst_rej", reject_pulse, 0);
        check_eq("rst_held", btn_held, 0);
        reset = 1'b0;
        cyc(5);

        code_raw = 16'h1234; cyc(4);
        enter_raw = 1'b1;
        wait_pulse("lat_clean", 10);
        check_eq("clean_acc", accept_pulse, 1);
        check_eq("clean_code", code_q, 16'h1234);
        check_eq("clean_held", btn_held, 1);
        release_btn();

        a0 = n_acc;
        repeat (2) begin
            enter_raw = 1'b1; cyc(3);
            enter_raw = 1'b0; cyc(3);
        end
        enter_raw = 1'b1;
        wait_pulse("lat_bounce", 10);
        cyc(2);
        check_eq("bounce_cnt", n_acc - a0, 1);
        release_btn();

        code_raw = 16'h1123; cyc(4);
        a0 = n_acc;
        enter_raw = 1'b1;
        wait_pulse("lat_repeat", 10);
        check_eq("repeat_rej", reject_pulse, 1);
        check_eq("repeat_code", code_q, 16'h1234);
        cyc(2);
        check_eq("repeat_noacc", n_acc - a0, 0);
        release_btn();

        code_raw = 16'h12A4; cyc(4);
        enter_raw = 1'b1;
        wait_pulse("lat_hex", 10);
        check_eq("hex_rej", reject_pulse, 1);
        check_eq("hex_acc", accept_pulse, 0);
        check_eq("hex_code", code_q, 16'h1234);
        release_btn();

        code_raw = 16'h1357; cyc(4);
        a0 = n_acc; r0 = n_rej;
        enter_raw = 1'b1;
        cyc(50);
        code_raw = 16'h5678;
        cyc(50);
        check_eq("hold_pulses", (n_acc - a0) + (n_rej - r0), 1);
        check_eq("hold_code", code_q, 16'h1357);

        enter_raw = 1'b0; cyc(4);
        enter_raw = 1'b1; cyc(20);
        check_eq("relbounce_held", btn_held, 1);
        check_eq("relbounce_pulses", (n_acc - a0) + (n_rej - r0), 1);
        enter_raw = 1'b0; cyc(20);
        check_eq("released_held", btn_held, 0);

        code_raw = 16'h2468; cyc(4);
        enter_raw = 1'b1;
        cyc(7);
        reset = 1'b1;
        cyc(1);
        check_eq("midrst_code", code_q, 16'h0000);
        check_eq("midrst_acc", accept_pulse, 0);
        check_eq("midrst_rej", reject_pulse, 0);
        check_eq("midrst_held", btn_held, 0);
        reset = 1'b0;
        wait_pulse("lat_after_rst", 10);
        check_eq("after_rst_acc", accept_pulse, 1);
        check_eq("after_rst_code", code_q, 16'h2468);
        release_btn();

        for (int it = 0; it < 25; it++) begin
            code_raw = rand_code();
            cyc(S + 1);
            a0 = n_acc; r0 = n_rej;
            repeat ($urandom_range(0, 3)) begin
                enter_raw = 1'b1; cyc(int'($urandom_range(1, D - 1)));
                enter_raw = 1'b0; cyc(int'($urandom_range(1, 4)));
            end
            enter_raw = 1'b1;
            cyc(int'($urandom_range(D + S + 2, 30)));
            if ($urandom_range(0, 2) == 0) begin
                code_raw = 16'($urandom);
                cyc(int'($urandom_range(1, 5)));
            end
            enter_raw = 1'b0; cyc(int'($urandom_range(1, D - 1)));
            enter_raw = 1'b1; cyc(int'($urandom_range(1, 3)));
            enter_raw = 1'b0;
            cyc(D + S + 3 + int'($urandom_range(0, 5)));
            check_eq("rnd_pulses", (n_acc - a0) + (n_rej - r0), 1);
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/entrada_cond.md
Name: entrada_cond

Overview:
- Input front end for the Bulls and Cows board: conditions the raw switch word and the enter push-button before they reach the game core.
- Synchronizes all asynchronous inputs and debounces enter_button.
- Emits exactly one accept or reject pulse per physical press.
- Validates the 4-digit BCD code: every nibble 0..9, all four distinct. Latches only valid codes and presents them to BullsCows.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required to accept a level change (10 ms at 100 MHz).
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers (min 2).
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived, not overridden).

Ports:
- clock  input  1  system clock, 100 MHz.
- reset  input  1  synchronous, active-high reset.
- code_raw  input  16  raw switches; [15:12] is digit 1 (leftmost), [3:0] is digit 4.
- enter_raw  input  1  raw enter button, active-high, bouncy.
- code_q  output  16  last accepted code.
- accept_pulse  output  1  one-cycle strobe: press with valid code; code_q updates on the same edge.
- reject_pulse  output  1  one-cycle strobe: press with invalid code; code_q unchanged.
- btn_held  output  1  debounced button level.

Behaviour:
- Reset values: code_q=16'h0000, accept_pulse=0, reject_pulse=0, btn_held=0. Synchronizers cleared, FSM in IDLE, counter 0.
- Synchronization:
  - enter_raw and all 16 code_raw bits pass through SYNC_STAGES flops, giving btn_s and code_s.
  - Code sampling uses code_s only.
- FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
  - IDLE: on btn_s=1, go to PRESS_WAIT with counter=1.
  - PRESS_WAIT, btn_s=1: counter increments. When counter reaches DEBOUNCE_CYCLES, go to HELD and fire the press event.
  - PRESS_WAIT, btn_s=0: return to IDLE with counter=0 (bounce rejected).
  - HELD: btn_held=1. On btn_s=0, go to RELEASE_WAIT with counter=1.
  - RELEASE_WAIT, btn_s=0: counter increments. At DEBOUNCE_CYCLES, go to IDLE and set btn_held=0.
  - RELEASE_WAIT, btn_s=1: return to HELD with counter=0.
- Press event, registered on the edge entering HELD:
  - Evaluate code_s at that edge.
  - Valid: accept_pulse=1 for one cycle; code_q<=code_s.
  - Invalid: reject_pulse=1 for one cycle; code_q holds.
  - accept_pulse and reject_pulse are never high together.
- Latency: a clean raw rising edge produces a pulse exactly SYNC_STAGES+DEBOUNCE_CYCLES cycles later.
- Holding the button gives no repeat pulses. A new pulse requires a debounced release, then a debounced press.
- Switch changes while HELD or in a wait state are ignored until the next press event.
- Reset mid-operation: everything returns to reset values on the next edge. A button still held at reset release restarts from IDLE, and its press counts after the full debounce time.
- The counter saturates at DEBOUNCE_CYCLES and never wraps.
- Validity check is combinational on code_s:
  - nibble > 9 on any digit → invalid.
  - any of the 6 digit pairs equal → invalid.

Decomposition:
- Package entrada_pkg:
  - typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} btn_state_t.
  - constant N_DIGITS=4.
  - function code_valid(logic [15:0]) returning logic. Shared with BullsCows for its own guess checking.
- One sub-module, sincronizador, parameterized by width and SYNC_STAGES. Instantiated once for 1 bit (button) and once for 16 bits (switches).

Test Plan (DEBOUNCE_CYCLES=8, SYNC_STAGES=2 for simulation):
- Clean press: code_raw=16'h1234, enter_raw held high → accept_pulse high exactly 10 cycles after the raw edge, for 1 cycle; code_q=16'h1234; btn_held=1.
- Bounce: enter_raw toggles 1,0,1,0 every 3 cycles, then stable high → single accept_pulse, 10 cycles after the final rising edge; no earlier pulse.
- Invalid codes:
  - code_raw=16'h1123 (repeat) → reject_pulse only; code_q keeps prior 16'h1234.
  - code_raw=16'h12A4 (nibble > 9) → reject_pulse only; code_q keeps prior 16'h1234.
- Long hold: enter_raw high 100 cycles with code_raw changed to 16'h5678 mid-hold → one pulse only; code_q reflects the value at the press event.
- Release bounce: after HELD, enter_raw drops for 4 cycles then returns high → stays HELD, btn_held stays 1, no new pulse.
- Reset mid-press: assert reset during PRESS_WAIT (counter=5) → all outputs 0 next cycle. With button still high after reset, accept_pulse occurs 10 cycles after reset deasserts.
